// File: rtl/regbank_param.sv
// Parametrised register bank: DEPTH words of DW bits with one byte-strobed
// write port and two independent registered read ports. Reads see the value
// the addressed register will hold after the current edge (write-first
// bypass), so clear, byte merge and hardwired-zero R0 show up on the read
// ports with no extra logic.
module regbank_param #(
    parameter int DW       = 32,
    parameter int DEPTH    = 4,
    parameter int AW       = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_strb,
    input  logic            rd_en_a,
    input  logic [AW-1:0]   rd_addr_a,
    output logic [DW-1:0]   rd_data_a,
    output logic            rd_valid_a,
    input  logic            rd_en_b,
    input  logic [AW-1:0]   rd_addr_b,
    output logic [DW-1:0]   rd_data_b,
    output logic            rd_valid_b
);

    localparam int NB   = DW / 8;
    localparam int SPAN = 1 << AW;

    // Post-edge value of every address in the full AW space. Entries at or
    // beyond DEPTH, and R0 when hardwired to zero, are constant 0, which is
    // exactly what both the write path and the read path need there.
    logic [DW-1:0] next_view [SPAN];
    logic [DW-1:0] byte_mask;

    // Expand the byte strobes into a bit mask used by every register's merge.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_mask
            assign byte_mask[8*gi +: 8] = {8{wr_strb[gi]}};
        end
    endgenerate

    generate
        for (gi = 0; gi < SPAN; gi++) begin : g_word
            if (gi < DEPTH && !(ZERO_REG != 0 && gi == 0)) begin : g_store
                logic [DW-1:0] value_reg;
                logic          wr_hit;

                assign wr_hit = wr_en && (wr_addr == AW'(gi));

                // Clear wins over a write; otherwise merge enabled bytes.
                assign next_view[gi] = clr    ? '0 :
                                       wr_hit ? ((value_reg & ~byte_mask) | (wr_data & byte_mask)) :
                                                value_reg;

                // Storage element for this word.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        value_reg <= '0;
                    end else begin
                        value_reg <= next_view[gi];
                    end
                end
            end else begin : g_const
                assign next_view[gi] = '0;
            end
        end
    endgenerate

    // Port A output stage: load on request, valid pulses for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            if (rd_en_a) begin
                rd_data_a <= next_view[rd_addr_a];
            end
        end
    end

    // Port B output stage: identical to port A and fully independent of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_b <= rd_en_b;
            if (rd_en_b) begin
                rd_data_b <= next_view[rd_addr_b];
            end
        end
    end

endmodule
